icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped instruction cache between the decoder's fetch port and memctrl's instruction port.
//  Hits return a word one cycle after the request; misses fetch the word through memctrl, fill the line, then return it.
//  Sits upstream of the decoder and downstream of memctrl; decoder-side ports mirror memctrl's if_* protocol, so it drops in transparently.
// PARAMETERS
//  INDEX_WIDTH  6   log2(lines); one 32-bit word per line; offset bits [1:0]
//  TAG_WIDTH    24  = 30-INDEX_WIDTH; tag = addr[31:INDEX_WIDTH+2]
// PORTS
//  clk_in         in   1   single clock, rising edge
//  rst_in         in   1   asynchronous, active-low reset
//  rdy_in         in   1   low: freeze all state, outputs hold
//  clear          in   1   pipeline flush (mispredict)
//  if_enable      in   1   decoder fetch request
//  if_addr        in   32  fetch address, [1:0]==0
//  if_ready       out  1   one-cycle pulse: inst valid
//  inst           out  32  returned instruction
//  mem_if_enable  out  1   request to memctrl
//  mem_if_addr    out  32  word address to memctrl
//  mem_if_ready   in   1   memctrl word returned
//  mem_inst       in   32  memctrl returned word
// BEHAVIOUR
//  - Reset (rst_in=0, async): all valid bits 0, state IDLE; if_ready=0, inst=0, mem_if_enable=0, mem_if_addr=0.
//  - States: IDLE, MISS.
//    - IDLE: if_enable=1 latches if_addr.
//      - Hit (valid[idx] and tag match): next cycle if_ready=1, inst=data[idx]; stay IDLE.
//      - Miss: next cycle mem_if_enable=1, mem_if_addr=latched addr; go MISS.
//    - MISS: mem_if_enable and mem_if_addr held steady until mem_if_ready.
//      - On mem_if_ready: write data/tag, set valid; next cycle if_ready=1, inst=mem_inst, mem_if_enable=0; go IDLE.
//      - if_enable during MISS is ignored.
//  - if_ready is high for exactly one cycle per accepted request. The decoder keeps if_enable high until it sees if_ready; the request is then re-evaluated as new.
//  - Back-to-back hits: one word per cycle. The cycle in which if_ready=1 may accept the next request.
//  - clear (highest priority, any state):
//    - Next cycle: state IDLE, if_ready=0, mem_if_enable=0.
//    - Any pending return is dropped.
//    - clear together with mem_if_ready: no fill, no return.
//    - Valid bits are kept; clear is not an invalidation.
//  - if_addr[1:0] is ignored (forced 0 on mem_if_addr).
//  - rdy_in=0 overrides everything except reset; a pending clear with rdy_in=0 is applied when rdy_in returns high, if still asserted.
//  - Index and tag fields wrap by truncation; no address range checks.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//    - adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset 0, wrap at 2^32.
//    - hit_cnt +1 per accepted hit; miss_cnt +1 per MISS entry (including later-cleared misses).
//  ICACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared defines header:
//    - ICACHE_INDEX_WIDTH default.
//    - IDLE/MISS state encodings.
//  Sub-module icache_array (valid/tag/data storage):
//    - combinational read by index.
//    - synchronous write by index.
//    - async-active-low clear of valid bits.
//  icache holds the FSM and output registers.
// TESTING
//  - Cold fetch 0x0000: mem_if_enable=1 with mem_if_addr=0x0; memctrl returns 0x00000013 after 4 cycles -> if_ready=1, inst=0x00000013; miss_cnt=1.
//  - Re-fetch 0x0000 -> if_ready one cycle later, inst=0x00000013, mem_if_enable stays 0; hit_cnt=1.
//  - Conflict:
//    - fetch 0x0100, then 0x0000 with INDEX_WIDTH=6 -> both miss.
//    - 0x0000 then refills.
//    - tag compare is correct.
//  - Flush mid-miss: fetch 0x0204, clear in 2nd MISS cycle -> mem_if_enable=0 next cycle, no if_ready; later 0x0204 misses again.
//  - clear together with mem_if_ready -> no if_ready, line 0x0204 stays invalid.
//  - Freeze and reset:
//    - rdy_in=0 for 3 cycles during MISS -> outputs and state frozen; completes normally after.
//    - rst_in=0 mid-MISS -> all outputs 0 immediately; prior hits now miss.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: default cache geometry, FSM state encoding and address helpers
// shared by icache and icache_array.
package icache_pkg;

  localparam int ICACHE_INDEX_WIDTH = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  // Instruction fetches are word aligned; the low two address bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the direct-mapped icache.
// Combinational read by index, synchronous write, valid bits cleared by async active-low reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [31:0]            rd_data,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [31:0]            wr_data
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  logic [31:0]          data_q [LINES];

  // Only the valid bits need a reset; stale tag/data behind a clear valid bit is never used.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache between the decoder fetch port and memctrl.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// Handshake: the decoder holds if_enable/if_addr until it sees the one-cycle if_ready
// pulse; any IDLE cycle (including the if_ready cycle) accepts a new request. Toward
// memctrl, mem_if_enable/mem_if_addr stay steady until mem_if_ready returns the word.
// rdy_in=0 freezes everything; clear aborts any outstanding request without invalidating.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] inst,
  output logic        mem_if_enable,
  output logic [31:0] mem_if_addr,
  input  logic        mem_if_ready,
  input  logic [31:0] mem_inst,
  output state_t      state_dbg
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  state_t state;

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] fill_idx;
  logic [TAG_WIDTH-1:0]   fill_tag;
  logic                   rd_valid;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic [31:0]            rd_data;
  logic                   hit;
  logic                   accept;
  logic                   fill_fire;
  logic [1:0]             unused_addr_lsb;

  assign req_idx  = if_addr[INDEX_WIDTH+1:2];
  assign req_tag  = if_addr[31:INDEX_WIDTH+2];
  // The outstanding miss address lives in mem_if_addr, so the fill uses it directly.
  assign fill_idx = mem_if_addr[INDEX_WIDTH+1:2];
  assign fill_tag = mem_if_addr[31:INDEX_WIDTH+2];
  assign unused_addr_lsb = if_addr[1:0];

  assign hit       = rd_valid && (rd_tag == req_tag);
  assign accept    = rdy_in && !clear && (state == ST_IDLE) && if_enable;
  assign fill_fire = rdy_in && !clear && (state == ST_MISS) && mem_if_ready;

  icache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_fire),
    .wr_idx   (fill_idx),
    .wr_tag   (fill_tag),
    .wr_data  (mem_inst)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= ST_IDLE;
      if_ready      <= 1'b0;
      inst          <= '0;
      mem_if_enable <= 1'b0;
      mem_if_addr   <= '0;
    end else if (rdy_in) begin
      if_ready <= 1'b0;
      if (clear) begin
        state         <= ST_IDLE;
        mem_if_enable <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (if_enable) begin
              if (hit) begin
                if_ready <= 1'b1;
                inst     <= rd_data;
              end else begin
                mem_if_enable <= 1'b1;
                mem_if_addr   <= word_align(if_addr);
                state         <= ST_MISS;
              end
            end
          end
          ST_MISS: begin
            if (mem_if_ready) begin
              if_ready      <= 1'b1;
              inst          <= mem_inst;
              mem_if_enable <= 1'b0;
              state         <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign state_dbg = state;

`ifdef ICACHE_STATS_EN
  // A miss counts on entry to MISS, so misses later aborted by clear are included.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (accept && hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (accept && !hit) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache; reference model tracks which word
// address each line holds and predicts hit/miss and returned words from memory contents.
module tb_icache;
  import icache_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        if_enable = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_if_ready = 1'b0;
  logic [31:0] mem_inst = '0;
  logic        if_ready;
  logic [31:0] inst;
  logic        mem_if_enable;
  logic [31:0] mem_if_addr;
  state_t      state_dbg;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: per line, whether it is filled and which word address it holds.
  logic        m_valid [64];
  logic [31:0] m_addr  [64];
  int          exp_hits = 0;
  int          exp_misses = 0;
  logic [31:0] exp_q[$];

  icache dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear         (clear),
    .if_enable     (if_enable),
    .if_addr       (if_addr),
    .if_ready      (if_ready),
    .inst          (inst),
    .mem_if_enable (mem_if_enable),
    .mem_if_addr   (mem_if_addr),
    .mem_if_ready  (mem_if_ready),
    .mem_inst      (mem_inst),
    .state_dbg     (state_dbg)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  // ---------------- memory and model helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h9e37_79b9;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    int l;
    l = line_of(a);
    return m_valid[l] && (m_addr[l] == {a[31:2], 2'b00});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    if_enable = 1'b0;
    repeat (n) begin
      @(posedge clk_in); #1;
      total++;
      if (if_ready !== 1'b0 || mem_if_enable !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet if_ready=%b mem_if_enable=%b required 0/0", if_ready, mem_if_enable);
      end
    end
  endtask

  // One complete fetch; memctrl answers after lat extra cycles when the model predicts a miss.
  task automatic do_fetch(input logic [31:0] a, input int lat);
    logic [31:0] wa;
    logic [31:0] exp_w;
    logic        exp_hit;
    wa = {a[31:2], 2'b00};
    exp_hit = model_hit(a);
    if_enable = 1'b1;
    if_addr = a;
    exp_q.push_back(mem_word(wa));
    @(posedge clk_in); #1;
    if_enable = 1'b0;
    if (exp_hit) begin
      exp_hits++;
      exp_w = exp_q.pop_front();
      total++;
      if (if_ready !== 1'b1 || mem_if_enable !== 1'b0 || inst !== exp_w) begin
        bad++;
        $display("FAIL hit_return addr=%h if_ready=%b mem_if_enable=%b inst=%h required 1/0/%h",
                 a, if_ready, mem_if_enable, inst, exp_w);
      end
    end else begin
      exp_misses++;
      total++;
      if (mem_if_enable !== 1'b1 || mem_if_addr !== wa || if_ready !== 1'b0) begin
        bad++;
        $display("FAIL miss_request addr=%h mem_if_enable=%b mem_if_addr=%h if_ready=%b required 1/%h/0",
                 a, mem_if_enable, mem_if_addr, if_ready, wa);
      end
      for (int i = 0; i < lat; i++) begin
        // Requests presented during a miss must be ignored.
        if_enable = 1'($urandom_range(0, 1));
        if_addr = $urandom;
        @(posedge clk_in); #1;
        total++;
        if (mem_if_enable !== 1'b1 || mem_if_addr !== wa || if_ready !== 1'b0) begin
          bad++;
          $display("FAIL miss_hold addr=%h mem_if_enable=%b mem_if_addr=%h if_ready=%b required 1/%h/0",
                   a, mem_if_enable, mem_if_addr, if_ready, wa);
        end
      end
      mem_if_ready = 1'b1;
      mem_inst = mem_word(wa);
      @(posedge clk_in); #1;
      mem_if_ready = 1'b0;
      mem_inst = $urandom;
      if_enable = 1'b0;
      exp_w = exp_q.pop_front();
      total++;
      if (if_ready !== 1'b1 || inst !== exp_w || mem_if_enable !== 1'b0) begin
        bad++;
        $display("FAIL miss_return addr=%h if_ready=%b inst=%h mem_if_enable=%b required 1/%h/0",
                 a, if_ready, inst, mem_if_enable, exp_w);
      end
      m_valid[line_of(a)] = 1'b1;
      m_addr[line_of(a)] = wa;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    total++;
    if (if_ready !== 1'b0 || inst !== 32'h0 || mem_if_enable !== 1'b0 ||
        mem_if_addr !== 32'h0 || state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state if_ready=%b inst=%h mem_if_enable=%b mem_if_addr=%h state=%0d required all 0",
               if_ready, inst, mem_if_enable, mem_if_addr, state_dbg);
    end
    rst_in = 1'b1;
    model_reset();
    idle(1);
  endtask

  task automatic test_stats(input string tag);
`ifdef ICACHE_STATS_EN
    total++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
      bad++;
      $display("FAIL stats_%s hit_cnt=%0d miss_cnt=%0d required %0d/%0d",
               tag, hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic test_cold_and_hit();
    do_fetch(32'h0000_0000, 4);
    test_stats("cold");
    do_fetch(32'h0000_0000, 0);
    test_stats("rehit");
    idle(1);
  endtask

  task automatic test_conflict();
    do_fetch(32'h0000_0100, 2);
    do_fetch(32'h0000_0000, 1);
    do_fetch(32'h0000_0000, 0);
    do_fetch(32'h0000_0002, 0);
    idle(1);
  endtask

  task automatic test_flush();
    // clear during the second MISS cycle
    if_enable = 1'b1;
    if_addr = 32'h0000_0204;
    @(posedge clk_in); #1;
    if_enable = 1'b0;
    exp_misses++;
    total++;
    if (mem_if_enable !== 1'b1 || mem_if_addr !== 32'h0000_0204) begin
      bad++;
      $display("FAIL flush_miss_start mem_if_enable=%b mem_if_addr=%h required 1/00000204", mem_if_enable, mem_if_addr);
    end
    @(posedge clk_in); #1;
    clear = 1'b1;
    @(posedge clk_in); #1;
    clear = 1'b0;
    total++;
    if (mem_if_enable !== 1'b0 || if_ready !== 1'b0 || state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL flush_abort mem_if_enable=%b if_ready=%b state=%0d required 0/0/IDLE",
               mem_if_enable, if_ready, state_dbg);
    end
    idle(3);
    // clear coinciding with the memctrl return: no fill, no return
    if_enable = 1'b1;
    if_addr = 32'h0000_0204;
    @(posedge clk_in); #1;
    if_enable = 1'b0;
    exp_misses++;
    total++;
    if (mem_if_enable !== 1'b1) begin
      bad++;
      $display("FAIL flush_remiss mem_if_enable=%b required 1", mem_if_enable);
    end
    clear = 1'b1;
    mem_if_ready = 1'b1;
    mem_inst = mem_word(32'h0000_0204);
    @(posedge clk_in); #1;
    clear = 1'b0;
    mem_if_ready = 1'b0;
    total++;
    if (if_ready !== 1'b0 || mem_if_enable !== 1'b0) begin
      bad++;
      $display("FAIL clear_with_fill if_ready=%b mem_if_enable=%b required 0/0", if_ready, mem_if_enable);
    end
    idle(2);
    do_fetch(32'h0000_0204, 1);
    do_fetch(32'h0000_0204, 0);
    test_stats("flush");
    idle(1);
  endtask

  task automatic test_freeze();
    logic [31:0] a;
    a = 32'h0300_0010;
    if_enable = 1'b1;
    if_addr = a;
    @(posedge clk_in); #1;
    if_enable = 1'b0;
    exp_misses++;
    rdy_in = 1'b0;
    clear = 1'b1;
    mem_if_ready = 1'b1;
    mem_inst = 32'hdead_beef;
    if_enable = 1'b1;
    if_addr = 32'h0000_0000;
    repeat (3) begin
      @(posedge clk_in); #1;
      total++;
      if (mem_if_enable !== 1'b1 || mem_if_addr !== a || if_ready !== 1'b0 || state_dbg !== ST_MISS) begin
        bad++;
        $display("FAIL freeze_hold mem_if_enable=%b mem_if_addr=%h if_ready=%b state=%0d required 1/%h/0/MISS",
                 mem_if_enable, mem_if_addr, if_ready, state_dbg, a);
      end
    end
    rdy_in = 1'b1;
    clear = 1'b0;
    mem_if_ready = 1'b0;
    if_enable = 1'b0;
    @(posedge clk_in); #1;
    mem_if_ready = 1'b1;
    mem_inst = mem_word(a);
    @(posedge clk_in); #1;
    mem_if_ready = 1'b0;
    total++;
    if (if_ready !== 1'b1 || inst !== mem_word(a)) begin
      bad++;
      $display("FAIL freeze_resume if_ready=%b inst=%h required 1/%h", if_ready, inst, mem_word(a));
    end
    m_valid[line_of(a)] = 1'b1;
    m_addr[line_of(a)] = a;
    do_fetch(a, 0);
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] tag_base [4];
    logic [31:0] a;
    tag_base[0] = 32'h0000_0000;
    tag_base[1] = 32'h0000_0100;
    tag_base[2] = 32'h8000_0100;
    tag_base[3] = 32'hffff_ff00;
    repeat (300) begin
      a = tag_base[$urandom_range(0, 3)] | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
      do_fetch(a, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    test_stats("random");
    idle(1);
  endtask

  task automatic test_reset_mid_miss();
    do_fetch(32'h0000_0000, 1);
    do_fetch(32'h0000_0000, 0);
    if_enable = 1'b1;
    if_addr = 32'h0400_0008;
    @(posedge clk_in); #1;
    if_enable = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    total++;
    if (if_ready !== 1'b0 || inst !== 32'h0 || mem_if_enable !== 1'b0 ||
        mem_if_addr !== 32'h0 || state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL async_reset if_ready=%b inst=%h mem_if_enable=%b mem_if_addr=%h state=%0d required all 0",
               if_ready, inst, mem_if_enable, mem_if_addr, state_dbg);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    model_reset();
    test_stats("after_reset");
    do_fetch(32'h0000_0000, 2);
    do_fetch(32'h0000_0000, 0);
    test_stats("final");
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i] = '0;
    end
    test_reset();
    test_cold_and_hit();
    test_conflict();
    test_flush();
    test_freeze();
    test_random();
    test_reset_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
